// File: rtl/regread_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// Holds a single registered response slot with back-pressure and XZR zeroing.
module regread_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      req_ready,
    output logic [AW-1:0]        rd_sel,
    input  logic [DW-1:0]        rd_data,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    input  logic                 rsp_ready
);

    localparam int            PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);

    // The all-ones address is the zero register: it reads as zero whatever the mux returns.
    function automatic logic [DW-1:0] xzr_zero(input logic [AW-1:0] addr,
                                                input logic [DW-1:0] data);
        return (&addr) ? '0 : data;
    endfunction

    logic [PW-1:0]   ptr_p0;
    logic [PW-1:0]   win_p0;
    logic [PW-1:0]   ptr_nxt_p0;
    logic [PW:0]     idx_p0;
    logic            found_p0;
    logic            grant_p0;
    logic [NREQ-1:0] win_oh_p0;
    logic [AW-1:0]   win_addr_p0;

    // Stage p0: pick the first valid requester starting at ptr, wrapping modulo NREQ
    always_comb begin
        win_p0   = ptr_p0;
        found_p0 = 1'b0;
        idx_p0   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_p0 = {1'b0, ptr_p0} + (PW+1)'(i);
            if (idx_p0 >= NREQ_W) begin
                idx_p0 = idx_p0 - NREQ_W;
            end
            if (!found_p0 && req_valid[idx_p0[PW-1:0]]) begin
                found_p0 = 1'b1;
                win_p0   = idx_p0[PW-1:0];
            end
        end
    end

    always_comb begin
        win_oh_p0   = '0;
        win_addr_p0 = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_p0 == PW'(k)) begin
                win_oh_p0[k] = 1'b1;
                win_addr_p0  = req_addr[k*AW +: AW];
            end
        end
    end

    // Slot is free when empty or being drained this cycle; nothing is granted under reset.
    assign grant_p0   = reset & (|req_valid) & (~(|rsp_valid) | rsp_ready);
    assign req_ready  = grant_p0 ? win_oh_p0 : '0;
    assign rd_sel     = grant_p0 ? win_addr_p0 : '0;
    assign ptr_nxt_p0 = (win_p0 == PW'(NREQ-1)) ? '0 : win_p0 + PW'(1);

    // Stage p1: registered response slot and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_p0    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (grant_p0) begin
            ptr_p0    <= ptr_nxt_p0;
            rsp_valid <= win_oh_p0;
            rsp_data  <= xzr_zero(win_addr_p0, rd_data);
        end else if (rsp_ready) begin
            rsp_valid <= '0;
        end
    end

endmodule

// File: tb/tb_regread_arbiter.sv
// Bench for regread_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_regread_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   req_ready;
    logic [AW-1:0]     rd_sel;
    logic [DW-1:0]     rd_data;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_ready;

    logic [DW-1:0]     regfile [32];

    // literal expectation for the current cycle; mask bits: 0 ready, 1 sel, 2 rsp_valid, 3 rsp_data
    logic              lit_on;
    string             lit_name;
    logic [3:0]        lit_m;
    logic [3:0]        lit_rdy;
    logic [4:0]        lit_sel;
    logic [3:0]        lit_rv;
    logic [63:0]       lit_data;
    int                pulses;

    int                n_total;
    int                n_pass;

    always #5 clk = ~clk;

    assign rd_data = regfile[rd_sel];

    regread_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total = n_total + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Compare process: model state is (owner, data, ptr) after the most recent edge.
    initial begin : compare
        int          m_owner;
        logic [63:0] m_data;
        int          m_ptr;
        int          seen;
        int          w;
        logic [3:0]  e_rdy;
        logic [4:0]  e_sel;
        logic [3:0]  e_rv;
        n_total = 0;
        n_pass  = 0;
        m_owner = -1;
        m_data  = '0;
        m_ptr   = 0;
        seen    = 0;
        forever begin
            @(negedge clk);
            if (pulses != seen || !reset) begin
                seen    = pulses;
                m_owner = -1;
                m_data  = '0;
                m_ptr   = 0;
            end
            e_rv = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
            w = -1;
            if (reset && (m_owner < 0 || rsp_ready)) w = rr_pick(req_valid, m_ptr);
            e_rdy = '0;
            e_sel = '0;
            if (w >= 0) begin
                e_rdy = 4'(1 << w);
                e_sel = req_addr[w*AW +: AW];
            end
            chk("req_ready", 64'(req_ready), 64'(e_rdy));
            chk("rd_sel",    64'(rd_sel),    64'(e_sel));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
            chk("rsp_data",  rsp_data,       m_data);
            if (lit_on) begin
                if (lit_m[0]) chk({lit_name, ".req_ready"}, 64'(req_ready), 64'(lit_rdy));
                if (lit_m[1]) chk({lit_name, ".rd_sel"},    64'(rd_sel),    64'(lit_sel));
                if (lit_m[2]) chk({lit_name, ".rsp_valid"}, 64'(rsp_valid), 64'(lit_rv));
                if (lit_m[3]) chk({lit_name, ".rsp_data"},  rsp_data,       lit_data);
            end
            if (reset) begin
                if (w >= 0) begin
                    m_owner = w;
                    m_data  = (e_sel == 5'(2**AW - 1)) ? 64'b0 : regfile[e_sel];
                    m_ptr   = (w + 1) % NREQ;
                end else if (rsp_ready) begin
                    m_owner = -1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        lit_on = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [3:0] m, input logic [3:0] r,
                       input logic [4:0] s, input logic [3:0] v, input logic [63:0] d);
        lit_name = nm;
        lit_m    = m;
        lit_rdy  = r;
        lit_sel  = s;
        lit_rv   = v;
        lit_data = d;
        lit_on   = 1'b1;
    endtask

    task automatic set_addr(input int k, input int a);
        req_addr[k*AW +: AW] = AW'(a);
    endtask

    // Short active-low pulse entirely between two rising edges.
    task automatic pulse_reset();
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        pulses = pulses + 1;
    endtask

    initial begin : drive
        logic [3:0] rr_exp [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        lit_on    = 1'b0;
        lit_name  = "";
        lit_m     = '0;
        lit_rdy   = '0;
        lit_sel   = '0;
        lit_rv    = '0;
        lit_data  = '0;
        pulses    = 0;
        for (int i = 0; i < 32; i++) regfile[i] = {$urandom, $urandom};
        regfile[3]  = 64'h1234;
        regfile[5]  = 64'hABCD;
        regfile[7]  = 64'h0777;
        regfile[31] = 64'hFFFF_FFFF_FFFF_FFFF;

        cyc();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        lit("reset_hold", 4'b1111, 4'b0, 5'd0, 4'b0, 64'h0);
        cyc();
        lit("reset_hold2", 4'b1111, 4'b0, 5'd0, 4'b0, 64'h0);
        cyc();

        reset = 1'b1;
        for (int k = 0; k < NREQ; k++) set_addr(k, 8 + k);
        for (int i = 0; i < 5; i++) begin
            lit($sformatf("round_robin%0d", i), 4'b0001, rr_exp[i], 5'd0, 4'b0, 64'h0);
            cyc();
        end

        req_valid = 4'b0001; set_addr(0, 3); rsp_ready = 1'b1;
        lit("single_grant", 4'b0011, 4'b0001, 5'd3, 4'b0, 64'h0);
        cyc();
        req_valid = 4'b0000; rsp_ready = 1'b0;
        lit("single_rsp", 4'b1100, 4'b0, 5'd0, 4'b0001, 64'h1234);
        cyc();

        for (int i = 0; i < 3; i++) begin
            req_valid = 4'b0010; set_addr(1, 5); rsp_ready = 1'b0;
            lit("backpressure_hold", 4'b1101, 4'b0000, 5'd0, 4'b0001, 64'h1234);
            cyc();
        end
        rsp_ready = 1'b1;
        lit("backpressure_release", 4'b0011, 4'b0010, 5'd5, 4'b0, 64'h0);
        cyc();
        req_valid = 4'b0000;
        lit("backpressure_rsp", 4'b1100, 4'b0, 5'd0, 4'b0010, 64'hABCD);
        cyc();

        req_valid = 4'b0001; set_addr(0, 31); rsp_ready = 1'b1;
        lit("xzr_grant", 4'b0011, 4'b0001, 5'd31, 4'b0, 64'h0);
        cyc();
        req_valid = 4'b0000; rsp_ready = 1'b0;
        lit("xzr_rsp", 4'b1100, 4'b0, 5'd0, 4'b0001, 64'h0);
        cyc();

        req_valid = 4'b0100; set_addr(2, 7); rsp_ready = 1'b1;
        lit("pre_reset_grant", 4'b0011, 4'b0100, 5'd7, 4'b0, 64'h0);
        cyc();
        req_valid = 4'b0000; rsp_ready = 1'b0;
        lit("pre_reset_rsp", 4'b1100, 4'b0, 5'd0, 4'b0100, 64'h0777);
        cyc();
        set_addr(0, 3); set_addr(3, 9);
        pulse_reset();
        req_valid = 4'b1001; rsp_ready = 1'b1;
        lit("post_reset", 4'b1111, 4'b0001, 5'd3, 4'b0000, 64'h0);
        cyc();
        req_valid = 4'b0000;
        lit("post_reset_rsp", 4'b1100, 4'b0, 5'd0, 4'b0001, 64'h1234);
        cyc();

        for (int n = 0; n < 3000; n++) begin
            req_valid = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            for (int k = 0; k < NREQ; k++) begin
                set_addr(k, ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 31)));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 249) == 0) pulse_reset();
            cyc();
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        cyc();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
